// File: rtl/schoolbook_pkg.sv
// Shared constants and types for the schoolbook shift-subtract divider.
package schoolbook_pkg;

  localparam int SB_N  = 521;
  localparam int SB_DW = 2 * SB_N;
  localparam int SB_CW = $clog2(SB_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_FLAG  = 1'b0;

endpackage

// File: rtl/schoolbook_div_step.sv
// One restoring-division step: shift a dividend bit into the partial remainder
// and subtract the divisor when it fits.
module schoolbook_div_step
  import schoolbook_pkg::*;
#(
  parameter int N = SB_N
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] d,
  input  logic         bit_in,
  output logic [N-1:0] p_next,
  output logic         q_bit
);

  logic [N:0] t;

  // Since p < d, t - d always fits in N bits, so an N-bit subtract on the low bits is exact.
  always_comb begin
    t      = {p, bit_in};
    q_bit  = 1'b0;
    p_next = t[N-1:0];
    if (t >= {1'b0, d}) begin
      q_bit  = 1'b1;
      p_next = t[N-1:0] - d;
    end
  end

endmodule

// File: rtl/schoolbook_div.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
module schoolbook_div
  import schoolbook_pkg::*;
#(
  parameter int N  = SB_N,
  parameter int CW = SB_CW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r
);

  localparam int            DW   = 2 * N;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [DW-1:0] a_reg;
  logic [N-1:0]  d_reg;
  logic [N-1:0]  p_reg;
  logic [N-1:0]  qs_reg;
  logic [CW-1:0] count;
  logic [N-1:0]  p_next;
  logic          q_bit;
  logic [N-1:0]  qs_next;

  schoolbook_div_step #(.N(N)) u_step (
    .p      (p_reg),
    .d      (d_reg),
    .bit_in (qs_reg[N-1]),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  assign qs_next = {qs_reg[N-2:0], q_bit};

  // The dividend's low half doubles as the quotient shift register during RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RST_STATE;
      busy   <= RST_FLAG;
      done   <= RST_FLAG;
      ovf    <= RST_FLAG;
      q      <= '0;
      r      <= '0;
      a_reg  <= '0;
      d_reg  <= '0;
      p_reg  <= '0;
      qs_reg <= '0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            d_reg <= b;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          // A high half at or above the divisor means the quotient needs more than N bits.
          if (a_reg[DW-1:N] >= d_reg) begin
            q     <= '0;
            r     <= '0;
            ovf   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            p_reg  <= a_reg[DW-1:N];
            qs_reg <= a_reg[N-1:0];
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          p_reg  <= p_next;
          qs_reg <= qs_next;
          count  <= count + CW'(1);
          if (count == LAST) begin
            q     <= qs_next;
            r     <= p_next;
            ovf   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/schoolbook_div.md
Name: schoolbook_div

Overview:
- Sequential shift-subtract (restoring) divider; the inverse of the schoolbook shift-add multiplier.
- Divides a 2N-bit dividend (a product-width operand) by an N-bit divisor and returns an N-bit quotient and an N-bit remainder.
- Resolves one quotient bit per clock, trading area for latency in the same way as the multiplier.
- Sits beside the multiplier in the large-integer arithmetic library; used for reduction and for product round-trip checks.

Parameters:
N, 521, divisor/quotient/remainder width; dividend width is 2N
CW, 10, iteration counter width, $clog2(N)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request; sampled only while busy=0
a  input  2N  dividend, sampled on accepted start
b  input  N  divisor, sampled on accepted start
busy  output  1  high from accepted start until result edge
done  output  1  one-cycle pulse, result valid
ovf  output  1  quotient does not fit in N bits (includes b=0); valid with done, held
q  output  N  quotient, held until next completion
r  output  N  remainder, held until next completion

Behaviour:
- Reset (rst=0, asynchronous): busy=0, done=0, ovf=0, q=0, r=0, state=IDLE, counter=0, internal operand registers=0. Applies mid-operation; the aborted division produces no done.
- All outputs are registered.
- State IDLE:
  - start=1 at an edge: latch A=a, D=b; busy<=1; go to CHECK.
  - start=0: done<=0.
- State CHECK (exactly 1 cycle):
  - If A[2N-1:N] >= D (covers D=0): q<=0, r<=0, ovf<=1, done<=1, busy<=0, go to IDLE.
  - Else: P<=A[2N-1:N], Qs<=A[N-1:0], count<=0, go to RUN.
- State RUN (N edges):
  - T = {P, Qs[N-1]} (N+1 bits).
  - If T >= D: P<=T-D (low N bits), bit=1. Else P<=T[N-1:0], bit=0.
  - Qs<={Qs[N-2:0], bit}; count<=count+1.
  - On the edge where count==N-1: q<=new Qs, r<=new P, ovf<=0, done<=1, busy<=0, go to IDLE.
- Latency, with E0 the accepting edge:
  - normal result: done high after edge E0+N+1 (522 cycles at default N).
  - overflow result: done high after edge E0+1.
- done clears on the next edge, unless that edge completes another operation.
- start while busy=1: ignored; the in-flight operation is unaffected.
- start during the done cycle: busy=0, so it is accepted. q/r/ovf keep the previous result until the new completion.
- Width rules:
  - Comparison and subtraction are N+1 bits wide. P < D holds invariantly, so P-D never underflows.
  - Result: a == q*b + r with r < b whenever ovf=0.
- Inputs a/b may change freely after the accepting edge.

Decomposition:
- Shared package schoolbook_pkg holds:
  - N default and derived DW=2N, CW;
  - the state enum {IDLE, CHECK, RUN};
  - the reset constants.
- One combinational sub-module, schoolbook_div_step:
  - inputs: P, D, incoming bit;
  - outputs: next P and quotient bit.
  - Instantiated once; the top holds the FSM, counter and registers.

Test Plan:
1. a=100, b=7, start one cycle -> done after 522 cycles with q=14, r=2, ovf=0; busy high throughout, low with done.
2. a=12345, b=0 -> done after E0+1 with ovf=1, q=0, r=0.
3. a=(2^521-1)^2, b=2^521-1 -> q=2^521-1, r=0, ovf=0. Also a=2^521*5+3, b=2^521-1 -> ovf=1 (high half 5 < b, so q fits) is wrong; use a=b<<521 -> ovf=1 (high half == divisor boundary).
4. Start a=100,b=7; re-pulse start at cycle 10 with a=9,b=2 -> ignored, result q=14,r=2. Start a=9,b=2 in the done cycle -> accepted, q=4,r=1, 522 cycles later.
5. rst=0 at cycle 200 of an operation -> all outputs 0 immediately, no done. After release, start a=50,b=5 -> q=10, r=0.
6. 1000 random (x,y) N-bit pairs: feed a=x*y+z (z<y), b=y -> q=x, r=z, ovf=0; and random a with a[2N-1:N]>=b -> ovf=1.
